// File: rtl/peer_link_monitor_pkg.sv
// rtl/peer_link_monitor_pkg.sv - shared encodings, field positions and defaults for the peer link monitor
package peer_link_monitor_pkg;

  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int unsigned DEF_WD_HALF_PERIOD_CYCLES = 1250000;
  localparam int unsigned DEF_ACK_TIMEOUT_CYCLES    = 125000;
  localparam int unsigned DEF_ALIVE_PERIOD_CYCLES   = 13750000;
  localparam int unsigned DEF_ALIVE_TOL_CYCLES      = 1250000;
  localparam int unsigned DEF_ALIVE_HIGH_MIN        = 625000;
  localparam int unsigned DEF_ALIVE_HIGH_MAX        = 1875000;

  typedef enum logic [1:0] {
    ALIVE_DOWN  = 2'b00,
    ALIVE_SYNC  = 2'b01,
    ALIVE_UP    = 2'b10,
    ALIVE_FAULT = 2'b11
  } alive_state_e;

  localparam int CFG_WD_EN      = 0;
  localparam int CFG_INSTANT_EN = 1;
  localparam int CFG_TRIG_EN    = 2;
  localparam int CFG_CLEAR      = 3;

  localparam int STS_STATE_LSB  = 0;
  localparam int STS_ACK_FAIL   = 2;
  localparam int STS_ALIVE_FAIL = 3;
  localparam int STS_TRIG       = 4;
  localparam int STS_ALIVE      = 5;
  localparam int STS_ACK        = 6;
  localparam int STS_INSTANT    = 7;
  localparam int STS_PERIOD_LSB = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous input bit
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/peer_link_monitor.sv
// rtl/peer_link_monitor.sv - peer link supervision: watchdog/ack check, alive heartbeat FSM, trigger relay
module peer_link_monitor
  import peer_link_monitor_pkg::*;
#(
  parameter int unsigned WD_HALF_PERIOD_CYCLES = DEF_WD_HALF_PERIOD_CYCLES,
  parameter int unsigned ACK_TIMEOUT_CYCLES    = DEF_ACK_TIMEOUT_CYCLES,
  parameter int unsigned ALIVE_PERIOD_CYCLES   = DEF_ALIVE_PERIOD_CYCLES,
  parameter int unsigned ALIVE_TOL_CYCLES      = DEF_ALIVE_TOL_CYCLES,
  parameter int unsigned ALIVE_HIGH_MIN        = DEF_ALIVE_HIGH_MIN,
  parameter int unsigned ALIVE_HIGH_MAX        = DEF_ALIVE_HIGH_MAX
) (
  input  logic        clk,
  input  logic        peripheral_areset,
  input  logic [7:0]  cfg,
  input  logic        reset_ack_in,
  input  logic        alive_signal_in,
  input  logic        master_trigger_in,
  output logic        watchdog_out,
  output logic        instant_reset_out,
  output logic        trigger_out,
  output logic [31:0] link_sts
);

  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(WD_HALF_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_MIN     = CNT_W'(ALIVE_PERIOD_CYCLES - ALIVE_TOL_CYCLES);
  localparam logic [CNT_W-1:0] PER_MAX     = CNT_W'(ALIVE_PERIOD_CYCLES + ALIVE_TOL_CYCLES);
  localparam logic [CNT_W-1:0] PER_TIMEOUT = CNT_W'(ALIVE_PERIOD_CYCLES + ALIVE_TOL_CYCLES + 1);
  localparam logic [CNT_W-1:0] HIGH_MIN    = CNT_W'(ALIVE_HIGH_MIN);
  localparam logic [CNT_W-1:0] HIGH_MAX    = CNT_W'(ALIVE_HIGH_MAX);

  logic ack_s, alive_s, trig_s;

  sync_2ff u_sync_ack   (.clk(clk), .rst(peripheral_areset), .d(reset_ack_in),      .q(ack_s));
  sync_2ff u_sync_alive (.clk(clk), .rst(peripheral_areset), .d(alive_signal_in),   .q(alive_s));
  sync_2ff u_sync_trig  (.clk(clk), .rst(peripheral_areset), .d(master_trigger_in), .q(trig_s));

  logic wd_en, instant_en, trig_en, clr;
  logic unused_cfg;

  assign wd_en      = cfg[CFG_WD_EN];
  assign instant_en = cfg[CFG_INSTANT_EN];
  assign trig_en    = cfg[CFG_TRIG_EN];
  assign clr        = cfg[CFG_CLEAR];
  assign unused_cfg = ^cfg[7:4];

  alive_state_e     state_q, state_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, wid_cnt_q, wid_cnt_d, last_per_q, last_per_d;
  logic             wd_q, wd_d, ack_fail_q, ack_fail_d, alive_fail_q, alive_fail_d;
  logic             alive_prev_q, alive_prev_d, instant_q, instant_d, trig_q, trig_d;
  logic             rise, edge_ok, mismatch;

  always_comb begin
    // Counter wraps to zero on every toggle so the half period never drifts.
    wd_cnt_d = '0;
    wd_d     = wd_q;
    if (wd_en) begin
      if (wd_cnt_q >= WD_LAST) wd_d = ~wd_q;
      else                     wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end

    mismatch   = wd_en && (ack_s != wd_q);
    mis_cnt_d  = (mismatch && !clr) ? sat_inc(mis_cnt_q) : '0;
    ack_fail_d = clr ? 1'b0 : (ack_fail_q | (mismatch && (mis_cnt_q >= ACK_LAST)));

    rise         = alive_s & ~alive_prev_q;
    alive_prev_d = alive_s;
    per_cnt_d    = rise ? CNT_W'(1) : sat_inc(per_cnt_q);
    wid_cnt_d    = rise ? CNT_W'(1) : (alive_s ? sat_inc(wid_cnt_q) : wid_cnt_q);
    edge_ok      = (per_cnt_q >= PER_MIN) && (per_cnt_q <= PER_MAX) &&
                   (wid_cnt_q >= HIGH_MIN) && (wid_cnt_q <= HIGH_MAX);
    last_per_d   = (rise && (state_q != ALIVE_DOWN)) ? per_cnt_q : last_per_q;

    instant_d = instant_en & (ack_fail_q | alive_fail_q);
    trig_d    = trig_en & trig_s & ~alive_fail_q;
  end

  always_comb begin
    state_d      = state_q;
    alive_fail_d = alive_fail_q;
    if (clr) begin
      state_d      = ALIVE_DOWN;
      alive_fail_d = 1'b0;
    end else begin
      case (state_q)
        ALIVE_DOWN: if (rise) state_d = ALIVE_SYNC;
        ALIVE_SYNC: if (rise && edge_ok) state_d = ALIVE_UP;
        ALIVE_UP: begin
          // An edge is always judged on its own measurement, even on the timeout cycle.
          if (rise ? !edge_ok : (per_cnt_q >= PER_TIMEOUT)) begin
            state_d      = ALIVE_FAULT;
            alive_fail_d = 1'b1;
          end
        end
        ALIVE_FAULT: state_d = ALIVE_FAULT;
        default:     state_d = ALIVE_DOWN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge peripheral_areset) begin
    if (peripheral_areset) begin
      state_q      <= ALIVE_DOWN;
      wd_cnt_q     <= '0;
      mis_cnt_q    <= '0;
      per_cnt_q    <= '0;
      wid_cnt_q    <= '0;
      last_per_q   <= '0;
      wd_q         <= 1'b0;
      ack_fail_q   <= 1'b0;
      alive_fail_q <= 1'b0;
      alive_prev_q <= 1'b0;
      instant_q    <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_cnt_q     <= wd_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      per_cnt_q    <= per_cnt_d;
      wid_cnt_q    <= wid_cnt_d;
      last_per_q   <= last_per_d;
      wd_q         <= wd_d;
      ack_fail_q   <= ack_fail_d;
      alive_fail_q <= alive_fail_d;
      alive_prev_q <= alive_prev_d;
      instant_q    <= instant_d;
      trig_q       <= trig_d;
    end
  end

  assign watchdog_out      = wd_q;
  assign instant_reset_out = instant_q;
  assign trigger_out       = trig_q;

  always_comb begin
    link_sts                            = '0;
    link_sts[STS_STATE_LSB +: 2]        = state_q;
    link_sts[STS_ACK_FAIL]              = ack_fail_q;
    link_sts[STS_ALIVE_FAIL]            = alive_fail_q;
    link_sts[STS_TRIG]                  = trig_s;
    link_sts[STS_ALIVE]                 = alive_s;
    link_sts[STS_ACK]                   = ack_s;
    link_sts[STS_INSTANT]               = instant_q;
    link_sts[STS_PERIOD_LSB +: CNT_W]   = last_per_q;
  end

endmodule

// File: doc/peer_link_monitor.md
PEER_LINK_MONITOR -- requirements
Module: peer_link_monitor

Interface
REQ-001 Parameter WD_HALF_PERIOD_CYCLES, default 1250000: watchdog_out toggle interval (10 ms at 125 MHz).
REQ-002 Parameter ACK_TIMEOUT_CYCLES, default 125000: maximum reset_ack/watchdog mismatch duration (1 ms).
REQ-003 Parameter ALIVE_PERIOD_CYCLES, default 13750000: nominal peer alive-signal period, rising edge to rising edge.
REQ-004 Parameter ALIVE_TOL_CYCLES, default 1250000: allowed ± deviation of the alive period.
REQ-005 Parameters ALIVE_HIGH_MIN/ALIVE_HIGH_MAX, defaults 625000/1875000: allowed alive high-pulse width, inclusive.
REQ-006 clk  in  1  sole clock, 125 MHz.
REQ-007 peripheral_areset  in  1  asynchronous, active-high reset.
REQ-008 cfg  in  8  bit0 watchdog enable; bit1 instant-reset enable; bit2 follow master trigger; bit3 clear faults (level); bits 7:4 ignored.
REQ-009 reset_ack_in  in  1  peer's echo of watchdog_out; asynchronous.
REQ-010 alive_signal_in  in  1  peer heartbeat; asynchronous.
REQ-011 master_trigger_in  in  1  peer master trigger; asynchronous.
REQ-012 watchdog_out  out  1  watchdog level toward peer.
REQ-013 instant_reset_out  out  1  request for immediate peer DAC reset.
REQ-014 trigger_out  out  1  local trigger derived from the peer master trigger.
REQ-015 link_sts  out  32  status word (REQ-031).

Function
REQ-016 The three async inputs SHALL pass through 2-FF synchronizers; all logic SHALL use only the synchronized versions.
REQ-017 With cfg[0]=1, a counter SHALL toggle watchdog_out every WD_HALF_PERIOD_CYCLES cycles; with cfg[0]=0, the counter SHALL clear and watchdog_out SHALL hold its level.
REQ-018 With cfg[0]=1, a mismatch counter SHALL increment each cycle that synced ack != watchdog_out and clear on match; reaching ACK_TIMEOUT_CYCLES SHALL set sticky ack_fail.
REQ-019 The alive FSM SHALL have states DOWN=00, SYNC=01, UP=10, FAULT=11.
REQ-020 A period counter SHALL restart at 1 on each synced alive rising edge and otherwise increment, saturating at 2^24-1; a width counter SHALL count synced-high cycles since the last rising edge.
REQ-021 DOWN: on the first rising edge the FSM SHALL go to SYNC.
REQ-022 SYNC: on a rising edge with period within ALIVE_PERIOD±ALIVE_TOL and last width within [HIGH_MIN,HIGH_MAX], the FSM SHALL go to UP; otherwise it SHALL stay in SYNC, re-measuring.
REQ-023 UP: a rising edge failing the checks of REQ-022, or the period counter reaching ALIVE_PERIOD+ALIVE_TOL+1 without an edge, SHALL move the FSM to FAULT and set sticky alive_fail.
REQ-024 Rising edge and timeout in the same cycle: the edge SHALL take priority and be checked normally.
REQ-025 FAULT SHALL persist until clear; SYNC and DOWN SHALL never raise alive_fail.
REQ-026 While cfg[3]=1: ack_fail and alive_fail SHALL clear, the FSM SHALL go to DOWN, and fault detection SHALL be suppressed; this SHALL take priority over a simultaneous fault.
REQ-027 instant_reset_out SHALL be registered as cfg[1] & (ack_fail | alive_fail), one cycle after the flag changes.
REQ-028 trigger_out SHALL be registered as cfg[2] & synced master_trigger & ~alive_fail; latency from master_trigger_in to trigger_out is 3 cycles.
REQ-029 Width arithmetic SHALL be unsigned; all comparisons SHALL use saturated counter values.
REQ-030 The watchdog counter SHALL wrap to 0 on each toggle; there SHALL be no cumulative drift.
REQ-031 link_sts: [1:0] FSM state, [2] ack_fail, [3] alive_fail, [4] synced master trigger, [5] synced alive, [6] synced ack, [7] instant_reset_out, [31:8] last measured alive period.

Reset
REQ-032 peripheral_areset SHALL asynchronously clear all registers, including synchronizers, to 0: outputs low, FSM DOWN, flags clear, period field 0.
REQ-033 Reset asserted mid-operation SHALL abort the measurement; after release, link-up SHALL require a fresh DOWN->SYNC->UP sequence.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, cfg bit indices, link_sts field positions and default cycle constants.
REQ-035 One sub-module, sync_2ff (1-bit, async active-high reset), SHALL be instantiated three times.

Verification (WD_HALF=8, ACK_TIMEOUT=4, PERIOD=20, TOL=2, HIGH_MIN=1, HIGH_MAX=4)
REQ-036 Test 1: cfg=0x01, ack looped back with 1-cycle delay -> watchdog_out toggles every 8 cycles; ack_fail stays 0 over 100 cycles.
REQ-037 Test 2: cfg=0x03, ack held 0 -> ack_fail set 4 cycles after the mismatch is seen in sync; instant_reset_out high 1 cycle later.
REQ-038 Test 3: alive period 20 with 3 high cycles, 3 pulses -> state 00->01->10; link_sts[31:8]=20.
REQ-039 Test 4: in UP, alive stops -> FAULT once the counter reaches 23; alive period 25 instead -> FAULT at that edge; cfg[3] pulse -> DOWN with flags clear.
REQ-040 Test 5: cfg=0x04, master_trigger pulse of 5 cycles -> trigger_out 5-cycle pulse delayed by 3; forced alive_fail -> trigger_out stays 0.
REQ-041 Test 6: assert reset in UP -> all outputs 0 immediately; after release, state 00.
